// File: rtl/prbs_stream_gen.sv
// Runtime-selectable PRBS7/9/15/23/31 word generator with a valid/ready output,
// seed loading, programmable burst length, done flag and single-bit error injection.
module prbs_stream_gen #(
  parameter int OUT_W    = 8,
  parameter int LEN_W    = 16,
  parameter int DEF_MODE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [2:0]       mode,
  input  logic [30:0]      seed,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             err_inject,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic [LEN_W-1:0] word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_reg;
  logic [30:0]      lfsr_reg;
  logic [2:0]       mode_reg;
  logic [LEN_W-1:0] len_reg;
  logic             err_reg;

  function automatic logic [4:0] poly_len(input logic [2:0] m);
    case (m)
      3'd0:    return 5'd7;
      3'd1:    return 5'd9;
      3'd2:    return 5'd15;
      3'd3:    return 5'd23;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] poly_tap(input logic [2:0] m);
    case (m)
      3'd0:    return 5'd6;
      3'd1:    return 5'd5;
      3'd2:    return 5'd14;
      3'd3:    return 5'd18;
      default: return 5'd28;
    endcase
  endfunction

  function automatic logic [30:0] poly_mask(input logic [2:0] m);
    return 31'h7FFFFFFF >> (5'd31 - poly_len(m));
  endfunction

  // Masking after the shift keeps the bits above L at zero.
  function automatic logic [30:0] lfsr_step(input logic [30:0] s, input logic [2:0] m);
    logic fb;
    fb = s[poly_len(m) - 5'd1] ^ s[poly_tap(m) - 5'd1];
    return {s[29:0], fb} & poly_mask(m);
  endfunction

  logic [30:0]      chain [OUT_W+1];
  logic [OUT_W-1:0] word_bits;
  logic [4:0]       msb_idx;

  assign msb_idx  = poly_len(mode_reg) - 5'd1;
  assign chain[0] = lfsr_reg;

  // Unrolled OUT_W-step LFSR; step gi produces out bit OUT_W-1-gi.
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_step
    assign word_bits[OUT_W-1-gi] = chain[gi][msb_idx];
    assign chain[gi+1]           = lfsr_step(chain[gi], mode_reg);
  end

  logic [30:0]      seed_masked;
  logic [30:0]      seed_val;
  logic [OUT_W-1:0] inj_mask;
  logic [LEN_W-1:0] wc_inc;

  always_comb begin
    seed_masked = seed & poly_mask(mode);
    seed_val    = (seed_masked == '0) ? poly_mask(mode) : seed_masked;
    inj_mask    = '0;
    inj_mask[0] = err_reg | err_inject;
    wc_inc      = word_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      lfsr_reg  <= 31'h7FFFFFFF;
      mode_reg  <= 3'(DEF_MODE);
      len_reg   <= '0;
      err_reg   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
    end else if (load) begin
      lfsr_reg  <= seed_val;
      mode_reg  <= mode;
      err_reg   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      word_cnt  <= '0;
      state_reg <= S_IDLE;
    end else begin
      if (err_inject) err_reg <= 1'b1;
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_reg   <= len;
            out_data  <= word_bits ^ inj_mask;
            lfsr_reg  <= chain[OUT_W];
            err_reg   <= 1'b0;
            out_valid <= 1'b1;
            done      <= 1'b0;
            word_cnt  <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_valid && out_ready) begin
            word_cnt <= wc_inc;
            if (len_reg != '0 && wc_inc == len_reg) begin
              // Final word accepted: LFSR is left where the next burst resumes.
              out_valid <= 1'b0;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              out_data <= word_bits ^ inj_mask;
              lfsr_reg <= chain[OUT_W];
              err_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Directed bench for prbs_stream_gen: an 8-bit-word instance for bursts/backpressure/errors
// and a 1-bit-word instance for the PRBS7 period check.
module tb_prbs_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load, start, err_inject, out_ready;
  logic [2:0]  mode;
  logic [30:0] seed;
  logic [15:0] len;
  logic [7:0]  out_data;
  logic        out_valid, done;
  logic [15:0] word_cnt;

  logic        load_b, start_b, err_inject_b, out_ready_b;
  logic [2:0]  mode_b;
  logic [30:0] seed_b;
  logic [15:0] len_b;
  logic [0:0]  out_data_b;
  logic        out_valid_b, done_b;
  logic [15:0] word_cnt_b;

  int checks = 0;
  int failures = 0;

  prbs_stream_gen #(.OUT_W(8), .LEN_W(16), .DEF_MODE(4)) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .seed(seed), .start(start),
    .len(len), .err_inject(err_inject), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .word_cnt(word_cnt)
  );

  prbs_stream_gen #(.OUT_W(1), .LEN_W(16), .DEF_MODE(4)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .mode(mode_b), .seed(seed_b), .start(start_b),
    .len(len_b), .err_inject(err_inject_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .done(done_b), .word_cnt(word_cnt_b)
  );

  task automatic pulse_load(input logic [2:0] m, input logic [30:0] s);
    load = 1'b1; mode = m; seed = s;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_data !== 8'h00 || out_valid !== 1'b0 || done !== 1'b0 || word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: data=%h valid=%b done=%b cnt=%0d required 00/0/0/0",
               out_data, out_valid, done, word_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: valid=%b done=%b required 0/0", out_valid, done);
    end
    out_ready = 1'b1;
    pulse_start(16'd1);
    checks++;
    if (out_data !== 8'hFF || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_default_prbs31: data=%h valid=%b required ff/1", out_data, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL reset_len1_done: done=%b cnt=%0d required 1/1", done, word_cnt);
    end
    $display("test_reset complete");
  endtask

  task automatic test_burst_len;
    out_ready = 1'b1;
    pulse_load(3'd0, 31'h7F);
    pulse_start(16'd2);
    checks++;
    if (out_data !== 8'hFE || out_valid !== 1'b1 || word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL burst_word0: data=%h valid=%b cnt=%0d required fe/1/0", out_data, out_valid, word_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_data !== 8'h04 || out_valid !== 1'b1 || word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL burst_word1: data=%h valid=%b cnt=%0d required 04/1/1", out_data, out_valid, word_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || word_cnt !== 16'd2) begin
      failures++;
      $display("FAIL burst_done: done=%b valid=%b cnt=%0d required 1/0/2", done, out_valid, word_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL burst_done_hold: done=%b valid=%b required 1/0", done, out_valid);
    end
    pulse_start(16'd1);
    checks++;
    if (out_data !== 8'h18 || out_valid !== 1'b1 || done !== 1'b0 || word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL restart_continue: data=%h valid=%b done=%b cnt=%0d required 18/1/0/0",
               out_data, out_valid, done, word_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL restart_done: done=%b cnt=%0d required 1/1", done, word_cnt);
    end
    $display("test_burst_len complete");
  endtask

  task automatic test_prbs7_period;
    logic       bits [254];
    logic [6:0] model;
    logic [7:0] first8;
    load_b = 1'b1; mode_b = 3'd0; seed_b = 31'h7F;
    @(negedge clk);
    load_b = 1'b0; out_ready_b = 1'b1; start_b = 1'b1; len_b = 16'd0;
    @(negedge clk);
    start_b = 1'b0;
    model = 7'h7F;
    for (int i = 0; i < 254; i++) begin
      bits[i] = out_data_b[0];
      checks++;
      if (out_valid_b !== 1'b1 || out_data_b[0] !== model[6]) begin
        failures++;
        $display("FAIL prbs7_bit%0d: data=%b valid=%b required %b/1", i, out_data_b[0], out_valid_b, model[6]);
      end
      model = {model[5:0], model[6] ^ model[5]};
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) first8[7-i] = bits[i];
    checks++;
    if (first8 !== 8'hFE) begin
      failures++;
      $display("FAIL prbs7_first8: got %h required fe", first8);
    end
    for (int i = 0; i < 127; i++) begin
      checks++;
      if (bits[i] !== bits[i+127]) begin
        failures++;
        $display("FAIL prbs7_period%0d: bit %0d=%b bit %0d=%b required equal", i, i, bits[i], i + 127, bits[i+127]);
      end
    end
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    $display("test_prbs7_period complete");
  endtask

  task automatic test_zero_seed;
    logic [7:0] words_a [4];
    logic [7:0] words_b [4];
    out_ready = 1'b1;
    pulse_load(3'd2, 31'h0);
    pulse_start(16'd0);
    for (int i = 0; i < 4; i++) begin
      words_a[i] = out_data;
      @(negedge clk);
    end
    pulse_load(3'd2, 31'h40007FFF);
    pulse_start(16'd0);
    for (int i = 0; i < 4; i++) begin
      words_b[i] = out_data;
      @(negedge clk);
    end
    checks++;
    if (words_a[0] !== 8'hFF || words_a[1] !== 8'hFE) begin
      failures++;
      $display("FAIL zero_seed_words: got %h %h required ff fe", words_a[0], words_a[1]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (words_a[i] !== words_b[i]) begin
        failures++;
        $display("FAIL zero_seed_equiv%0d: zero-seed %h explicit-seed %h required equal", i, words_a[i], words_b[i]);
      end
    end
    $display("test_zero_seed complete");
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_w [4];
    logic       pat [6];
    int         idx;
    exp_w[0] = 8'hFE; exp_w[1] = 8'h04; exp_w[2] = 8'h18; exp_w[3] = 8'h51;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    out_ready = 1'b0;
    pulse_load(3'd0, 31'h7F);
    pulse_start(16'd4);
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (out_data !== exp_w[idx] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_cyc%0d: data=%h valid=%b required %h/1", k, out_data, out_valid, exp_w[idx]);
      end
      out_ready = pat[k];
      if (pat[k]) idx++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || word_cnt !== 16'd4) begin
      failures++;
      $display("FAIL backpressure_done: done=%b valid=%b cnt=%0d required 1/0/4", done, out_valid, word_cnt);
    end
    $display("test_backpressure complete");
  endtask

  task automatic test_err_inject;
    out_ready = 1'b1;
    pulse_load(3'd0, 31'h7F);
    pulse_start(16'd4);
    checks++;
    if (out_data !== 8'hFE) begin
      failures++;
      $display("FAIL err_word0: got %h required fe", out_data);
    end
    err_inject = 1'b1;
    @(negedge clk);
    err_inject = 1'b0;
    checks++;
    if (out_data !== 8'h05) begin
      failures++;
      $display("FAIL err_word1_flipped: got %h required 05", out_data);
    end
    @(negedge clk);
    checks++;
    if (out_data !== 8'h18) begin
      failures++;
      $display("FAIL err_word2_clean: got %h required 18", out_data);
    end
    out_ready = 1'b0; err_inject = 1'b1;
    @(negedge clk);
    err_inject = 1'b0;
    checks++;
    if (out_data !== 8'h18 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL err_stall_hold: data=%h valid=%b required 18/1", out_data, out_valid);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_data !== 8'h50 || word_cnt !== 16'd3) begin
      failures++;
      $display("FAIL err_sticky_word3: data=%h cnt=%0d required 50/3", out_data, word_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL err_done: done=%b required 1", done);
    end
    $display("test_err_inject complete");
  endtask

  task automatic test_load_abort;
    out_ready = 1'b1;
    pulse_load(3'd2, 31'h0);
    pulse_start(16'd0);
    repeat (2) @(negedge clk);
    load = 1'b1; mode = 3'd0; seed = 31'h7F; start = 1'b1; len = 16'd5;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: valid=%b cnt=%0d done=%b required 0/0/0", out_valid, word_cnt, done);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_start_ignored: valid=%b required 0", out_valid);
    end
    pulse_start(16'd1);
    checks++;
    if (out_data !== 8'hFE || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_new_seed: data=%h valid=%b required fe/1", out_data, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL abort_done: done=%b cnt=%0d required 1/1", done, word_cnt);
    end
    $display("test_load_abort complete");
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    pulse_start(16'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || word_cnt !== 16'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: data=%h valid=%b cnt=%0d done=%b required 00/0/0/0",
               out_data, out_valid, word_cnt, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: valid=%b required 0", out_valid);
    end
    pulse_start(16'd1);
    checks++;
    if (out_data !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid_restart: data=%h required ff", out_data);
    end
    $display("test_reset_mid complete");
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0; start = 1'b0; err_inject = 1'b0; out_ready = 1'b0;
    mode = 3'd0; seed = 31'h0; len = 16'd0;
    load_b = 1'b0; start_b = 1'b0; err_inject_b = 1'b0; out_ready_b = 1'b0;
    mode_b = 3'd0; seed_b = 31'h0; len_b = 16'd0;
    test_reset;
    test_burst_len;
    test_prbs7_period;
    test_zero_seed;
    test_backpressure;
    test_err_inject;
    test_load_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
